// File: rtl/pipeifq_pkg.sv
// rtl/pipeifq_pkg.sv - shared types and constants for the fetch-to-decode instruction queue
package pipeifq_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INS = 32'h0;

  typedef struct packed {
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] ins;
  } entry_t;

endpackage

// File: rtl/pipeifq_mem.sv
// rtl/pipeifq_mem.sv - DEPTH x 64 entry array, one synchronous write port, one asynchronous read port
module pipeifq_mem
  import pipeifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  // Contents are never reset; validity is tracked by the pointers in pipeifq.
  entry_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipeifq.sv
// rtl/pipeifq.sv - IF-to-ID instruction queue, first-word-fall-through; PIPEIFQ_BYPASS_EN adds same-cycle bypass
module pipeifq
  import pipeifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_pc4,
  input  logic [WORD_W-1:0] in_ins,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_pc4,
  output logic [WORD_W-1:0] out_ins,
  input  logic              out_ready,
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic   stored_valid;
  logic   bypass;
  logic   enq;
  logic   deq;
  entry_t wr_entry;
  entry_t rd_entry;

  assign stored_valid = (count_q != '0);
  assign in_ready     = (count_q != FULL_CNT);
  assign count        = count_q;

`ifdef PIPEIFQ_BYPASS_EN
  assign bypass = ~stored_valid & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry taken by decode in the same cycle never touches storage.
  assign enq = in_valid & in_ready & ~flush & ~(bypass & out_ready);
  assign deq = stored_valid & out_ready & ~flush;

  assign wr_entry = '{pc4: in_pc4, ins: in_ins};

  pipeifq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (enq),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty queue presents a nop bubble to decode.
  always_comb begin
    out_valid = stored_valid | bypass;
    out_pc4   = '0;
    out_ins   = NOP_INS;
    if (bypass) begin
      out_pc4 = in_pc4;
      out_ins = in_ins;
    end else if (stored_valid) begin
      out_pc4 = rd_entry.pc4;
      out_ins = rd_entry.ins;
    end
  end

endmodule

// File: tb/tb_pipeifq.sv
// tb/tb_pipeifq.sv - self-checking scoreboard bench for pipeifq
module tb_pipeifq;
  import pipeifq_pkg::*;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_pc4;
  logic [31:0] in_ins;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc4;
  logic [31:0] out_ins;
  logic        out_ready;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;
  logic [63:0] mq[$];

  pipeifq #(.DEPTH(4), .AW(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_pc4    (in_pc4),
    .in_ins    (in_ins),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc4   (out_pc4),
    .out_ins   (out_ins),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle, check outputs against the scoreboard before the edge, then update it.
  task automatic cycle(input logic iv, input logic [31:0] pc4, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    logic        byp, exp_v, enq, deq;
    logic [63:0] exp_out;
    in_valid  = iv;
    in_pc4    = pc4;
    in_ins    = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    byp = 1'b0;
`ifdef PIPEIFQ_BYPASS_EN
    byp = (mq.size() == 0) && iv && !fl;
`endif
    exp_v   = (mq.size() != 0) || byp;
    exp_out = byp ? {pc4, ins} : ((mq.size() != 0) ? mq[0] : 64'h0);
    check("out_valid", 64'(out_valid), 64'(exp_v));
    check("out_pc4_ins", {out_pc4, out_ins}, exp_out);
    check("in_ready", 64'(in_ready), 64'(mq.size() != 4));
    check("count", 64'(count), 64'(mq.size()));
    enq = iv && (mq.size() != 4) && !fl && !(byp && ordy);
    deq = (mq.size() != 0) && ordy && !fl;
    @(posedge clock);
    if (fl) begin
      mq.delete();
    end else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back({pc4, ins});
    end
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_pc4    = '0;
    in_ins    = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_ins", 64'(out_ins), 64'h0);
    check("rst_out_pc4", 64'(out_pc4), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_count", 64'(count), 64'h0);
    resetn = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // single enqueue, visible after one edge
    cycle(1'b1, 32'h4, 32'h8C010004, 1'b0, 1'b0);
    check("enq1_out_ins", 64'(out_ins), 64'h8C010004);
    check("enq1_count", 64'(count), 64'h1);

    // fill to four, fifth attempt refused
    cycle(1'b1, 32'h8, 32'h8C020008, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 32'h8C03000C, 1'b0, 1'b0);
    cycle(1'b1, 32'h10, 32'h8C040010, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'h4);
    check("full_in_ready", 64'(in_ready), 64'h0);
    cycle(1'b1, 32'h14, 32'hDEADBEEF, 1'b0, 1'b0);
    check("full_hold_count", 64'(count), 64'h4);

    // drain in order
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drained_out_ins", 64'(out_ins), 64'h0);

    // simultaneous enqueue/dequeue at count 2, across pointer wrap
    cycle(1'b1, 32'h20, 32'h00000020, 1'b0, 1'b0);
    cycle(1'b1, 32'h24, 32'h00000000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h28 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b1, 1'b0);
    check("steady_count", 64'(count), 64'h2);

    // flush with same-cycle enqueue and dequeue at count 3
    cycle(1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0);
    check("pre_flush_count", 64'(count), 64'h3);
    cycle(1'b1, 32'h44, 32'h22222222, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'h0);
    check("flush_out_valid", 64'(out_valid), 64'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // asynchronous reset with three entries stored
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h50 + 32'(4 * i), 32'hB0000000 + 32'(i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'h0);
    check("async_rst_out_valid", 64'(out_valid), 64'h0);
    check("async_rst_in_ready", 64'(in_ready), 64'h1);
    mq.delete();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // empty queue, input offered with decode ready
    cycle(1'b1, 32'h60, 32'h00221820, 1'b1, 1'b0);
`ifdef PIPEIFQ_BYPASS_EN
    check("bypass_count_after", 64'(count), 64'h0);
`else
    check("nobypass_count_after", 64'(count), 64'h1);
    check("nobypass_out_ins_next", 64'(out_ins), 64'h00221820);
`endif
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeifq.md
Name: pipeifq

Overview:
- Fetch-to-decode instruction queue: the receiving end of the IF stage outputs (`pc4`, `ins`).
- Buffers fetched instructions so fetch keeps running while decode stalls.
- Presents the head entry to the ID stage first-word-fall-through.
- Discards all buffered entries on a taken branch/jump.
- Sits between the IF stage and the ID stage in the 5-stage pipelined CPU, replacing the plain IF/ID register.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- clock  input  1  pipeline clock.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  IF stage presents a fetched instruction this cycle.
- in_pc4  input  32  pc+4 of the fetched instruction.
- in_ins  input  32  fetched instruction; already 32'h0 when the IF stage squashed it.
- in_ready  output  1  queue accepts an entry this cycle; equals (count != DEPTH).
- flush  input  1  branch/jump taken (`pcsource` nonzero); discard all entries.
- out_valid  output  1  head entry valid.
- out_pc4  output  32  pc4 of the head entry; 0 when empty.
- out_ins  output  32  instruction of the head entry; 32'h0 (nop) when empty.
- out_ready  input  1  ID stage consumes the head; low while decode stalls.
- count  output  AW+1  number of stored entries, 0..DEPTH.

Behaviour:
- Reset (resetn low, asynchronous):
  - wr_ptr, rd_ptr and count are 0.
  - Storage contents are don't-care.
  - Outputs: out_valid=0, out_ins=0, out_pc4=0, in_ready=1.
  - Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Enqueue: on a rising edge with in_valid & in_ready & ~flush, write {in_pc4, in_ins} at wr_ptr and increment wr_ptr modulo DEPTH.
- Dequeue: on a rising edge with out_valid & out_ready & ~flush, increment rd_ptr modulo DEPTH.
- Simultaneous enqueue and dequeue: count is unchanged.
  - Allowed when full only if in_ready was high; since in_ready is low when full, no enqueue occurs when full.
- Count update: count += enq − deq, computed in AW+1 bits. Pointers wrap naturally at DEPTH.
- Outputs are combinational reads of the entry at rd_ptr:
  - out_valid = (count != 0).
  - When out_valid is 0, out_ins and out_pc4 are forced to 0, so decode sees a nop bubble.
- Latency: an entry enqueued at edge N appears at the outputs after edge N. Minimum IF→ID latency is 1 cycle, identical to a plain pipeline register.
- Flush on a rising edge:
  - wr_ptr=rd_ptr=0 and count=0.
  - Any same-cycle enqueue and dequeue are both ignored.
  - out_valid=0 from the following cycle.
  - flush has priority over all other events.
- Full (count==DEPTH): in_ready=0, and the IF stage must hold its PC.
- Empty (count==0): out_valid=0 and out_ready is ignored.
- in_valid while in_ready=0: the entry is not written; the IF stage holds it.
- A zero in_ins with in_valid=1 is stored as a normal entry; squashed instructions are not filtered.

Optional Feature:
- Macro: PIPEIFQ_BYPASS_EN.
- Defined: when count==0 & in_valid & ~flush, the inputs drive out_pc4/out_ins combinationally and out_valid=1 in the same cycle.
  - If out_ready is also high, the entry is consumed and not written: pointers and count are unchanged.
  - Otherwise it is written normally.
  - Latency becomes 0 cycles.
- Undefined: no bypass; outputs come only from stored entries, with 1-cycle minimum latency.

Decomposition:
- Shared package:
  - NOP_INS = 32'h0.
  - WORD_W = 32.
  - Typedef for the queue entry {pc4[31:0], ins[31:0]} (64 bits).
- Sub-module pipeifq_mem: a DEPTH×64 register array with one synchronous write port and one asynchronous read port. Not reset.
- Pointer, count and flush control logic stays in pipeifq.

Test Plan:
- Reset, then idle → out_valid=0, out_ins=32'h0, out_pc4=0, in_ready=1, count=0.
  - Assert resetn low mid-queue with 3 entries → count=0 immediately, before the next edge.
- Enqueue 0x8C010004/pc4=0x4 with out_ready=0 → after 1 edge: out_valid=1, out_ins=0x8C010004, out_pc4=0x4, count=1.
- Fill 4 entries with out_ready=0 → in_ready=0, count=4.
  - A 5th in_valid is not stored.
  - Raise out_ready for 4 cycles → the entries come out in order, then out_valid=0, out_ins=0.
- At count=2, assert in_valid and out_ready together for 3 cycles → count stays 2 and output order is preserved across pointer wrap.
- At count=3, flush=1 together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, and the same-cycle input is discarded.
- With PIPEIFQ_BYPASS_EN defined and the queue empty, in_valid=1 with ins=0x00221820 and out_ready=1 → same-cycle out_valid=1, out_ins=0x00221820, and count remains 0 after the edge.
  - Without the macro → out_valid=0 that cycle, and the entry appears on the next cycle.
